result_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the 8-bit calculator adder. It captures the 9-bit unsigned result `{carry, sum[7:0]}` (0–511) and the adder's overflow flag on a start strobe. It converts the result to three BCD digits using iterative shift-and-add-3 (double dabble), one bit per cycle. The registered digits and the overflow flag then drive the seven-segment display stage.

---
 rtl/result_bcd_converter_pkg.sv | 6 +
 rtl/bcd_add3.sv | 7 +
 rtl/result_bcd_converter.sv | 72 +++++++
 tb/tb_result_bcd_converter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/result_bcd_converter_pkg.sv
// result_bcd_converter_pkg: shared FSM encoding and default widths for the result BCD path
package result_bcd_converter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_NBITS = 9;
  localparam int DEF_NDIGITS = 3;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 to any digit of 5 or more
module bcd_add3 (
  input  logic [3:0] in,
  output logic [3:0] out
);
  assign out = (in >= 4'd5) ? in + 4'd3 : in;
endmodule

// File: rtl/result_bcd_converter.sv
// result_bcd_converter: captures {carry,sum} and converts it to BCD digits one bit per cycle
module result_bcd_converter
  import result_bcd_converter_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int NDIGITS = DEF_NDIGITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] sum,
  input  logic       carry,
  input  logic       overflow,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf,
  output logic       busy,
  output logic       done
);
  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int BW = 4 * NDIGITS;
  state_t state;
  logic [NBITS-1:0] bin;
  logic [BW-1:0] bcd, adj;
  logic [CW-1:0] cnt;
  logic ovf_cap;
  for (genvar g = 0; g < NDIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.in(bcd[4*g +: 4]), .out(adj[4*g +: 4]));
  end
  // busy is registered alongside state so it mirrors (state != IDLE) without a comb path
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf_cap <= 1'b0;
      hundreds <= 4'd0;
      tens <= 4'd0;
      ones <= 4'd0;
      ovf <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bin <= NBITS'({carry, sum});
          ovf_cap <= overflow;
          bcd <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NBITS - 1)) state <= DONE;
        end
        DONE: begin
          {hundreds, tens, ones} <= bcd[11:0];
          ovf <= ovf_cap;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter: directed scenario checks for the sequential binary-to-BCD converter
module tb_result_bcd_converter;
  logic clk = 0, rst = 1, start = 0, carry = 0, overflow = 0;
  logic [7:0] sum = 0;
  logic [3:0] hundreds, tens, ones;
  logic ovf, busy, done;
  int pass_cnt = 0, total = 0;

  result_bcd_converter dut (
    .clk(clk), .rst(rst), .start(start), .sum(sum), .carry(carry), .overflow(overflow),
    .hundreds(hundreds), .tens(tens), .ones(ones), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start, then waits (bounded) for done; reports latency, busy cycles and output stability
  task automatic convert(input logic [7:0] s, input logic c, input logic o,
                         output int lat, output int bcyc, output logic stable);
    logic [12:0] prev;
    prev = {hundreds, tens, ones, ovf};
    sum = s; carry = c; overflow = o; start = 1;
    step();
    start = 0; sum = 8'h00; carry = 0; overflow = 0;
    lat = 0; bcyc = 0; stable = 1;
    while (!done && lat < 20) begin
      if (busy) bcyc++;
      if ({hundreds, tens, ones, ovf} !== prev) stable = 0;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    total++; if ({hundreds, tens, ones} !== 12'h000) $display("FAIL reset_digits got %h want 000", {hundreds, tens, ones}); else pass_cnt++;
    total++; if ({ovf, busy, done} !== 3'b000) $display("FAIL reset_flags got %b want 000", {ovf, busy, done}); else pass_cnt++;
    rst = 0;
    step();
  endtask

  task automatic test_zero();
    int lat, bc; logic st;
    convert(8'h00, 0, 0, lat, bc, st);
    total++; if (lat !== 10) $display("FAIL zero_latency got %0d want 10", lat); else pass_cnt++;
    total++; if (bc !== 10) $display("FAIL zero_busy_cycles got %0d want 10", bc); else pass_cnt++;
    total++; if ({hundreds, tens, ones, ovf} !== 13'b0000_0000_0000_0) $display("FAIL zero_result got %h/%h/%h ovf %b want 0/0/0 ovf 0", hundreds, tens, ones, ovf); else pass_cnt++;
    step();
    total++; if (done !== 1'b0) $display("FAIL zero_done_width got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_max();
    int lat, bc; logic st;
    convert(8'hFF, 0, 0, lat, bc, st);
    total++; if ({hundreds, tens, ones, ovf} !== {4'd2, 4'd5, 4'd5, 1'b0}) $display("FAIL max255 got %h/%h/%h ovf %b want 2/5/5 ovf 0", hundreds, tens, ones, ovf); else pass_cnt++;
    step();
    convert(8'hFF, 1, 1, lat, bc, st);
    total++; if (lat !== 10) $display("FAIL max511_latency got %0d want 10", lat); else pass_cnt++;
    total++; if ({hundreds, tens, ones, ovf} !== {4'd5, 4'd1, 4'd1, 1'b1}) $display("FAIL max511 got %h/%h/%h ovf %b want 5/1/1 ovf 1", hundreds, tens, ones, ovf); else pass_cnt++;
    step();
  endtask

  task automatic test_hold();
    int lat, bc; logic st;
    convert(8'h64, 0, 0, lat, bc, st);
    total++; if ({hundreds, tens, ones} !== 12'h100) $display("FAIL val100 got %h want 100", {hundreds, tens, ones}); else pass_cnt++;
    step();
    convert(8'h09, 0, 0, lat, bc, st);
    total++; if (st !== 1'b1) $display("FAIL hold_stable got %b want 1", st); else pass_cnt++;
    total++; if ({hundreds, tens, ones} !== 12'h009) $display("FAIL val9 got %h want 009", {hundreds, tens, ones}); else pass_cnt++;
    step();
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    sum = 8'h2A; start = 1;
    step();
    start = 0;
    for (int k = 1; k <= 24; k++) begin
      start = (k == 3 || k == 9);
      sum = 8'hC8;
      step();
      if (done) ndone++;
    end
    start = 0;
    total++; if (ndone !== 1) $display("FAIL ignore_done_count got %0d want 1", ndone); else pass_cnt++;
    total++; if ({hundreds, tens, ones} !== 12'h042) $display("FAIL ignore_result got %h want 042", {hundreds, tens, ones}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bc, ndone = 0; logic st;
    sum = 8'h7B; start = 1;
    step();
    start = 0;
    for (int k = 1; k < 5; k++) step();
    rst = 1;
    step();
    rst = 0;
    total++; if ({hundreds, tens, ones, ovf, busy, done} !== 15'd0) $display("FAIL midreset_clear got %h/%h/%h ovf %b busy %b done %b want all 0", hundreds, tens, ones, ovf, busy, done); else pass_cnt++;
    for (int k = 0; k < 15; k++) begin
      step();
      if (done) ndone++;
    end
    total++; if (ndone !== 0) $display("FAIL midreset_no_done got %0d want 0", ndone); else pass_cnt++;
    convert(8'h7B, 0, 0, lat, bc, st);
    total++; if ({hundreds, tens, ones} !== 12'h123) $display("FAIL after_reset got %h want 123", {hundreds, tens, ones}); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    int ndone = 0, first = -1, last = -1, bad_gap = 0, bad_val = 0;
    sum = 8'h0A; start = 1;
    step();
    for (int k = 1; k <= 35; k++) begin
      step();
      if (done) begin
        if (first < 0) first = k;
        else if (k - last != 11) bad_gap++;
        if ({hundreds, tens, ones} !== 12'h010) bad_val++;
        last = k;
        ndone++;
      end
    end
    start = 0;
    total++; if (ndone !== 3) $display("FAIL b2b_count got %0d want 3", ndone); else pass_cnt++;
    total++; if (first !== 10) $display("FAIL b2b_first got %0d want 10", first); else pass_cnt++;
    total++; if (bad_gap !== 0) $display("FAIL b2b_spacing got %0d bad gaps want 0", bad_gap); else pass_cnt++;
    total++; if (bad_val !== 0) $display("FAIL b2b_value got %0d bad results want 0", bad_val); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_hold();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
